// File: rtl/perf_counter_unit_pkg.sv
// Shared types for the performance counter unit:
// counter index map, value and increment types.
package perf_counter_unit_pkg;

  localparam int PERF_COUNTER_NUM = 8;
  localparam int PERF_INC_WIDTH = 4;

  typedef enum logic [2:0] {
    PC_CYCLE,
    PC_IC_MISS,
    PC_LOAD_MISS,
    PC_STORE_MISS,
    PC_STLF_FAIL,
    PC_MEMDEP_MISS,
    PC_BR_MISS,
    PC_BR_MISS_DEC
  } PerfCounterIndex;

  typedef logic [63:0] PerfCounterValue;
  typedef logic [PERF_INC_WIDTH-1:0] PerfCounterInc;

  typedef struct packed {
    PerfCounterValue [PERF_COUNTER_NUM-1:0] value;
  } PerfCounterPath;

endpackage

// File: rtl/perf_counter_cell.sv
// One 64-bit event counter with increment amount,
// count inhibit and 32-bit half write.
module perf_counter_cell
  import perf_counter_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  PerfCounterInc   inc,
  input  logic            inhibit,
  input  logic            wrEn,
  input  logic            wrHi,
  input  logic [31:0]     wrData,
  output PerfCounterValue value
);

  // A write drops the same-cycle increment, carry included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (wrEn) begin
      if (wrHi) value[63:32] <= wrData;
      else      value[31:0]  <= wrData;
    end else if (!inhibit) begin
      value <= value + PerfCounterValue'(inc);
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance event counters with a 32-bit CSR port and
// a high-half shadow for atomic 64-bit reads on RV32.
module perf_counter_unit
  import perf_counter_unit_pkg::*;
#(
  parameter int LOAD_ISSUE_WIDTH  = 2,
  parameter int STORE_ISSUE_WIDTH = 1,
  parameter int CSR_DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH     = 2 * CSR_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         icMiss,
  input  logic [LOAD_ISSUE_WIDTH-1:0]  loadMiss,
  input  logic [STORE_ISSUE_WIDTH-1:0] storeMiss,
  input  logic                         storeLoadForwardingFail,
  input  logic                         memDepPredMiss,
  input  logic                         branchPredMiss,
  input  logic                         branchPredMissDetectedOnDecode,
  input  logic [7:0]                   inhibit,
  input  logic                         csrRdReq,
  input  logic [2:0]                   csrRdIdx,
  input  logic                         csrRdHi,
  output logic                         csrRdValid,
  output logic [CSR_DATA_WIDTH-1:0]    csrRdData,
  input  logic                         csrWrEn,
  input  logic [2:0]                   csrWrIdx,
  input  logic                         csrWrHi,
  input  logic [CSR_DATA_WIDTH-1:0]    csrWrData
);

  localparam int HI_W = COUNTER_WIDTH - CSR_DATA_WIDTH;

  PerfCounterInc   inc   [PERF_COUNTER_NUM];
  PerfCounterValue value [PERF_COUNTER_NUM];

  always_comb begin
    for (int i = 0; i < PERF_COUNTER_NUM; i++) inc[i] = '0;
    inc[PC_CYCLE]       = PerfCounterInc'(1);
    inc[PC_IC_MISS]     = PerfCounterInc'(icMiss);
    inc[PC_STLF_FAIL]   = PerfCounterInc'(storeLoadForwardingFail);
    inc[PC_MEMDEP_MISS] = PerfCounterInc'(memDepPredMiss);
    inc[PC_BR_MISS]     = PerfCounterInc'(branchPredMiss);
    inc[PC_BR_MISS_DEC] =
      PerfCounterInc'(branchPredMissDetectedOnDecode);
    for (int i = 0; i < LOAD_ISSUE_WIDTH; i++)
      inc[PC_LOAD_MISS] += PerfCounterInc'(loadMiss[i]);
    for (int i = 0; i < STORE_ISSUE_WIDTH; i++)
      inc[PC_STORE_MISS] += PerfCounterInc'(storeMiss[i]);
  end

  for (genvar g = 0; g < PERF_COUNTER_NUM; g++) begin : g_cell
    perf_counter_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc[g]),
      .inhibit (inhibit[g]),
      .wrEn    (csrWrEn && csrWrIdx == 3'(g)),
      .wrHi    (csrWrHi),
      .wrData  (csrWrData),
      .value   (value[g])
    );
  end

  logic [HI_W-1:0]          shadow;
  logic [2:0]               shadowIdx;
  logic                     shadowValid;
  logic [COUNTER_WIDTH-1:0] rdVal;
  logic                     rdLo;
  logic                     shadowHit;
  logic [2:0]               nextShadowIdx;
  logic                     shadowClr;

  assign rdVal         = value[csrRdIdx];
  assign rdLo          = csrRdReq && !csrRdHi;
  assign shadowHit     = shadowValid && shadowIdx == csrRdIdx;
  assign nextShadowIdx = rdLo ? csrRdIdx : shadowIdx;
  // A high write to the snapshotted counter invalidates it,
  // even when the snapshot is taken in the same cycle.
  assign shadowClr     = csrWrEn && csrWrHi &&
                         csrWrIdx == nextShadowIdx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csrRdValid  <= 1'b0;
      csrRdData   <= '0;
      shadow      <= '0;
      shadowIdx   <= '0;
      shadowValid <= 1'b0;
    end else begin
      csrRdValid <= csrRdReq;
      if (csrRdReq) begin
        if (!csrRdHi)
          csrRdData <= rdVal[CSR_DATA_WIDTH-1:0];
        else if (shadowHit)
          csrRdData <= shadow;
        else
          csrRdData <= rdVal[COUNTER_WIDTH-1:CSR_DATA_WIDTH];
      end
      if (rdLo) begin
        shadow    <= rdVal[COUNTER_WIDTH-1:CSR_DATA_WIDTH];
        shadowIdx <= csrRdIdx;
      end
      if (shadowClr)  shadowValid <= 1'b0;
      else if (rdLo)  shadowValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Scoreboard bench for perf_counter_unit: a 64-bit
// arithmetic model predicts each CSR read response.
module tb_perf_counter_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        icMiss, stlf, memDep, brMiss, brMissDec;
  logic [1:0]  loadMiss;
  logic [0:0]  storeMiss;
  logic [7:0]  inhibit;
  logic        csrRdReq, csrRdHi, csrWrEn, csrWrHi;
  logic [2:0]  csrRdIdx, csrWrIdx;
  logic [31:0] csrWrData;
  logic        csrRdValid;
  logic [31:0] csrRdData;

  always #5 clk = ~clk;

  perf_counter_unit dut (
    .clk                            (clk),
    .rst                            (rst),
    .icMiss                         (icMiss),
    .loadMiss                       (loadMiss),
    .storeMiss                      (storeMiss),
    .storeLoadForwardingFail        (stlf),
    .memDepPredMiss                 (memDep),
    .branchPredMiss                 (brMiss),
    .branchPredMissDetectedOnDecode (brMissDec),
    .inhibit                        (inhibit),
    .csrRdReq                       (csrRdReq),
    .csrRdIdx                       (csrRdIdx),
    .csrRdHi                        (csrRdHi),
    .csrRdValid                     (csrRdValid),
    .csrRdData                      (csrRdData),
    .csrWrEn                        (csrWrEn),
    .csrWrIdx                       (csrWrIdx),
    .csrWrHi                        (csrWrHi),
    .csrWrData                      (csrWrData)
  );

  logic [63:0] m [8];
  logic [31:0] sh;
  logic [2:0]  sidx;
  logic        sv;
  logic [31:0] q [$];
  logic [63:0] cur;
  logic [31:0] expv;
  int compared = 0;
  int mismatched = 0;

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m[i] = '0;
    sh = '0;
    sidx = '0;
    sv = 1'b0;
    q.delete();
  endtask

  function automatic int amount(int i);
    case (i)
      0: return 1;
      1: return int'(icMiss);
      2: return $countones(loadMiss);
      3: return $countones(storeMiss);
      4: return int'(stlf);
      5: return int'(memDep);
      6: return int'(brMiss);
      default: return int'(brMissDec);
    endcase
  endfunction

  always @(negedge rst) clear_model();

  always @(posedge clk) begin
    if (rst) begin
      if (csrRdReq) begin
        cur = m[csrRdIdx];
        if (!csrRdHi) begin
          q.push_back(cur[31:0]);
          sh = cur[63:32];
          sidx = csrRdIdx;
          sv = 1'b1;
        end else if (sv && sidx == csrRdIdx) begin
          q.push_back(sh);
        end else begin
          q.push_back(cur[63:32]);
        end
      end
      if (csrWrEn && csrWrHi && csrWrIdx == sidx) sv = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (csrWrEn && int'(csrWrIdx) == i) begin
          if (csrWrHi) m[i] = {csrWrData, m[i][31:0]};
          else         m[i] = {m[i][63:32], csrWrData};
        end else if (!inhibit[i]) begin
          m[i] = m[i] + 64'(amount(i));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && csrRdValid) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL rd_unexpected: got %h, no read pending",
                 csrRdData);
      end else begin
        expv = q.pop_front();
        if (csrRdData !== expv) begin
          mismatched++;
          $display("FAIL rd_data: got %h expected %h",
                   csrRdData, expv);
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got,
                       logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    {icMiss, stlf, memDep, brMiss, brMissDec} = '0;
    loadMiss = '0;
    storeMiss = '0;
    inhibit = '0;
    csrRdReq = 0; csrRdHi = 0; csrRdIdx = '0;
    csrWrEn = 0; csrWrHi = 0; csrWrIdx = '0; csrWrData = '0;
  endtask

  task automatic rd(int idx, logic hi);
    csrRdReq = 1; csrRdIdx = 3'(idx); csrRdHi = hi;
    cyc();
    csrRdReq = 0;
  endtask

  task automatic wr(int idx, logic hi, logic [31:0] d);
    csrWrEn = 1; csrWrIdx = 3'(idx); csrWrHi = hi;
    csrWrData = d;
    cyc();
    csrWrEn = 0;
  endtask

  task automatic pulse_br(int n);
    for (int i = 0; i < n; i++) begin
      brMiss = 1; cyc(); brMiss = 0; cyc();
    end
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check("reset_valid", 32'(csrRdValid), 32'd0);
    check("reset_data", csrRdData, 32'd0);
    repeat (2) cyc();
    rst = 1;
  endtask

  initial begin
    clear_model();
    quiet();
    repeat (3) cyc();
    check("por_valid", 32'(csrRdValid), 32'd0);
    check("por_data", csrRdData, 32'd0);
    rst = 1;

    repeat (10) cyc();
    rd(0, 0);
    cyc();

    loadMiss = 2'b11;
    repeat (3) cyc();
    loadMiss = 2'b01;
    cyc();
    loadMiss = 2'b00;
    rd(2, 0);
    for (int i = 0; i < 4; i++) begin
      storeMiss = 1; cyc(); storeMiss = 0; cyc();
    end
    rd(3, 0);

    wr(1, 1, 32'h0);
    wr(1, 0, 32'hFFFF_FFFF);
    icMiss = 1; cyc(); icMiss = 0; cyc();
    rd(1, 0);
    rd(1, 1);

    wr(6, 0, 32'hFFFF_FFFF);
    pulse_br(1);
    rd(6, 0);
    pulse_br(3);
    rd(6, 1);
    wr(6, 1, 32'h5);
    rd(6, 1);

    wr(0, 0, 32'hFFFF_FFFF);
    cyc();
    rd(0, 1);

    inhibit = 8'h20;
    for (int i = 0; i < 5; i++) begin
      memDep = 1; cyc(); memDep = 0; cyc();
    end
    rd(5, 0);
    inhibit = 8'h00;
    memDep = 1;
    wr(5, 0, 32'd9);
    memDep = 0;
    rd(5, 0);
    cyc();

    csrRdReq = 1; csrRdIdx = 3'd2; csrRdHi = 0;
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("post_reset_valid", 32'(csrRdValid), 32'd0);
    @(posedge clk);
    #1;
    csrRdReq = 0;
    for (int i = 0; i < 8; i++) begin
      rd(i, 0);
      rd(i, 1);
    end

    for (int n = 0; n < 3000; n++) begin
      icMiss    = $urandom_range(0, 1);
      stlf      = $urandom_range(0, 1);
      memDep    = $urandom_range(0, 1);
      brMiss    = $urandom_range(0, 1);
      brMissDec = $urandom_range(0, 1);
      loadMiss  = 2'($urandom);
      storeMiss = 1'($urandom);
      inhibit   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h0;
      csrRdReq  = $urandom_range(0, 1);
      csrRdIdx  = 3'($urandom);
      csrRdHi   = $urandom_range(0, 1);
      csrWrEn   = ($urandom_range(0, 7) == 0);
      csrWrIdx  = ($urandom_range(0, 1) == 0) ? csrRdIdx : 3'($urandom);
      csrWrHi   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: csrWrData = 32'hFFFF_FFFF;
        1: csrWrData = 32'hFFFF_FFFD;
        default: csrWrData = $urandom;
      endcase
      if (n % 1000 == 500) do_reset();
      else cyc();
    end

    quiet();
    repeat (3) cyc();
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL rd_missing: %0d reads pending, expected 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
